axis_pl2ps_fifo_ctrl: RTL and testbench
=======================================

// Module: axis_pl2ps_fifo_ctrl
// PURPOSE
//  Serial-to-AXI4-Stream framer on the PL->PS path. Takes the demodulator's 1-bit/clk
//  data stream, hunts for the start-frame delimiter (SFD) and captures the following
//  DATA_WIDTH bits LSB-first. Presents each word as a single-beat AXIS packet to the
//  downstream AXI4-Stream data FIFO (which bridges to the PS/modulator clock domain).
// PARAMETERS
//  DATA_WIDTH  32     payload bits per frame = tdata width (multiple of 8)
//  SFD_WIDTH   8      delimiter length in bits
//  SFD         8'hD5  delimiter value; arrives MSB first (SFD[SFD_WIDTH-1] first)
// PORTS
//  clk            in   1             single clock; all logic on rising edge
//  rst            in   1             synchronous, active-high reset
//  data_in        in   1             demod serial bit, sampled every clk
//  m_axis_tdata   out  DATA_WIDTH    captured payload word
//  m_axis_tkeep   out  DATA_WIDTH/8  byte enables
//  m_axis_tlast   out  1             end of packet
//  m_axis_tready  in   1             FIFO ready
//  m_axis_tvalid  out  1             word valid
// BEHAVIOUR
//  Reset (rst=1 at clk edge): state=HUNT, shift reg=0, bit cnt=0, tvalid=0, tdata=0,
//   tkeep=0, tlast=0. Reset overrides everything, including a mid-capture/held word.
//  FSM states: HUNT -> CAPTURE -> HOLD -> HUNT.
//  HUNT: shift reg (SFD_WIDTH) shifts left each clk, data_in into LSB. If
//   {sr[SFD_WIDTH-2:0],data_in}==SFD at an edge -> CAPTURE next cycle, cnt=0.
//   Partial/overlapping matches must still detect (sliding window, no reset on mismatch).
//  CAPTURE: each clk store data_in into tdata[cnt], cnt++ (first bit after SFD -> bit 0).
//   On the edge storing bit DATA_WIDTH-1 -> HOLD; tvalid=1 from the next cycle,
//   i.e. tvalid rises one clk after the last payload bit is sampled.
//  HOLD: tvalid=1, tkeep=all ones, tlast=1 (every frame = one-beat packet), tdata stable.
//   Transfer on edge with tvalid&&tready; next cycle tvalid=0, tlast=0, tkeep=0 -> HUNT.
//   tvalid never drops without handshake; tdata/tkeep/tlast must not change while valid.
//   Serial bits arriving in HOLD are discarded (no buffering); a frame sent while the FIFO
//   stalls is lost. tready may be high before tvalid; no combinational tready->tvalid path.
//  On entry to HUNT (from HOLD or reset) shift reg is cleared, so payload bits left in the
//   window can never fake an SFD; SFD detection needs SFD_WIDTH fresh bits.
//  tdata holds last word after handshake (don't-care); data_in with X outside frames ignored.
//  cnt width = clog2(DATA_WIDTH); no wrap beyond DATA_WIDTH-1.
// TESTING
//  1 Reset: rst=1 5 clks, data_in toggling -> tvalid=0, tlast=0, tkeep=0 throughout.
//  2 Frame: bits 1,1,0,1,0,1,0,1 (0xD5 MSB first) then 0x76543210 LSB first, tready=1 ->
//    tvalid 1 clk after bit 31, tdata=0x76543210, tkeep=4'hF, tlast=1, one-cycle beat.
//  3 Backpressure: frame 0xFEDCBA98 with tready=0 for 20 clks -> tvalid/tdata held stable,
//    single transfer when tready=1, then tvalid=0; bits sent during HOLD produce nothing.
//  4 Noise/partial SFD: 0xD4, 1,1 then 0xD5 then 0x76543210 -> exactly one word 0x76543210.
//  5 SFD inside payload: payload 0x000000D5-style pattern, then idle zeros -> one word only,
//    no spurious second frame after HUNT re-entry.
//  6 Reset mid-capture after 16 payload bits, then full frame 0xFEDCBA98 -> only that word.

Source files
------------

// File: rtl/axis_pl2ps_fifo_ctrl_if.sv
// -----------------------------------------------------------------------------
// axis_if
//   Single-direction AXI4-Stream bundle used between the serial framer and the
//   downstream AXIS data FIFO.
//   tdata  : payload word
//   tkeep  : byte enables (one per payload byte)
//   tlast  : end of packet
//   tvalid : source has a beat
//   tready : sink accepts the beat
//   master : drives tdata/tkeep/tlast/tvalid, observes tready
//   slave  : observes tdata/tkeep/tlast/tvalid, drives tready
// -----------------------------------------------------------------------------
interface axis_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;
    logic                    tvalid;
    logic                    tready;

    modport master (
        output tdata,
        output tkeep,
        output tlast,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tlast,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/axis_pl2ps_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// axis_pl2ps_fifo_ctrl
//   Serial-to-AXI4-Stream framer on the PL->PS path. Hunts the 1-bit/clk demod
//   stream for the start-frame delimiter (sent MSB first), captures the next
//   DATA_WIDTH bits LSB first and offers the word as a one-beat AXIS packet.
//   Bits arriving while a word is waiting for the FIFO are dropped.
// Ports
//   clk     : single clock, rising edge
//   rst     : synchronous, active-high reset
//   data_in : demodulated serial bit, sampled every clock
//   m_axis  : AXI4-Stream master (tdata/tkeep/tlast/tvalid out, tready in)
// -----------------------------------------------------------------------------
module axis_pl2ps_fifo_ctrl #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           SFD_WIDTH  = 8,
    parameter logic [SFD_WIDTH-1:0]  SFD        = 8'hD5
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   data_in,
    axis_if.master m_axis
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam int unsigned KEEP_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_CAPTURE,
        ST_HOLD
    } state_e;

    state_e                  state_q,  state_d;
    // Only the SFD_WIDTH-1 older bits need storing: the live bit completes the
    // SFD_WIDTH-bit sliding window.
    logic [SFD_WIDTH-2:0]    sr_q,     sr_d;
    logic [CNT_W-1:0]        cnt_q,    cnt_d;
    logic [DATA_WIDTH-1:0]   tdata_q,  tdata_d;
    logic [KEEP_W-1:0]       tkeep_q,  tkeep_d;
    logic                    tlast_q,  tlast_d;
    logic                    tvalid_q, tvalid_d;
    logic [SFD_WIDTH-1:0]    window;

    assign window = {sr_q, data_in};

    // NOTE: every register, the payload word included, is cleared by reset so
    // the AXIS outputs are defined from the first cycle after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all
            // registers update together from the values sampled at the edge.
            state_q  <= ST_HUNT;
            sr_q     <= '0;
            cnt_q    <= '0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a hold-value default first, so no
        // path through the case statement can infer a latch.
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q;

        unique case (state_q)
            ST_HUNT: begin
                // Sliding window: never cleared on mismatch, so overlapping
                // partial delimiters are still found.
                sr_d = window[SFD_WIDTH-2:0];
                if (window == SFD) begin
                    state_d = ST_CAPTURE;
                    cnt_d   = '0;
                    sr_d    = '0;
                end
            end

            ST_CAPTURE: begin
                tdata_d[cnt_q] = data_in;
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_HOLD;
                    tvalid_d = 1'b1;
                    tkeep_d  = '1;
                    tlast_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_HOLD: begin
                // Serial bits are ignored here. Window is cleared on the way
                // back to HUNT so stale payload bits cannot fake a delimiter.
                if (m_axis.tready) begin
                    state_d  = ST_HUNT;
                    tvalid_d = 1'b0;
                    tkeep_d  = '0;
                    tlast_d  = 1'b0;
                    sr_d     = '0;
                end
            end

            default: begin
                state_d = ST_HUNT;
                sr_d    = '0;
            end
        endcase
    end

    // All outputs come straight from registers: no tready->tvalid comb path.
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tkeep  = tkeep_q;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tvalid = tvalid_q;

endmodule

// File: tb/tb_axis_pl2ps_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_axis_pl2ps_fifo_ctrl
//   Self-checking bench for axis_pl2ps_fifo_ctrl. A behavioural model (bit
//   history queue, payload counter, pending word) predicts the AXIS outputs;
//   a compare process checks them every cycle, directed scenarios pin the
//   model with literal values, and a random phase exercises noise and stalls.
// -----------------------------------------------------------------------------
module tb_axis_pl2ps_fifo_ctrl;

    localparam int          DW    = 32;
    localparam logic [7:0]  SFD_V = 8'hD5;

    logic clk = 1'b0;
    logic rst;
    logic data_in;

    always #5 clk = ~clk;

    axis_if #(.DATA_WIDTH(DW)) m_axis ();

    axis_pl2ps_fifo_ctrl #(
        .DATA_WIDTH (DW),
        .SFD_WIDTH  (8),
        .SFD        (SFD_V)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .m_axis  (m_axis)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          hist[$];      // bits seen since the last (re)start of hunting
    bit          m_capturing = 1'b0;
    int          m_got       = 0;
    bit          m_valid     = 1'b0;
    logic [31:0] m_word      = '0;
    int          m_xfers     = 0;
    logic [31:0] m_last      = '0;

    function automatic logic [7:0] last8();
        logic [7:0] v = '0;
        for (int i = 0; i < 8; i++) v = {v[6:0], logic'(hist[hist.size() - 8 + i])};
        return v;
    endfunction

    always @(posedge clk) begin : model
        if (rst) begin
            hist.delete();
            m_capturing = 1'b0;
            m_got       = 0;
            m_valid     = 1'b0;
            m_word      = '0;
        end else if (m_valid) begin
            if (m_axis.tready) begin
                m_xfers++;
                m_last  = m_word;
                m_valid = 1'b0;
                hist.delete();
            end
        end else if (m_capturing) begin
            m_word[m_got] = data_in;
            m_got++;
            if (m_got == DW) begin
                m_capturing = 1'b0;
                m_valid     = 1'b1;
            end
        end else begin
            hist.push_back(data_in);
            if (hist.size() > 8) void'(hist.pop_front());
            if (hist.size() == 8 && last8() == SFD_V) begin
                m_capturing = 1'b1;
                m_got       = 0;
                hist.delete();
            end
        end
    end

    // Handshakes actually performed by the DUT.
    int          d_xfers = 0;
    logic [31:0] d_last  = '0;
    always @(posedge clk) begin
        if (!rst && m_axis.tvalid === 1'b1 && m_axis.tready === 1'b1) begin
            d_xfers++;
            d_last = m_axis.tdata;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            check("tvalid", {63'd0, m_axis.tvalid}, {63'd0, m_valid});
            check("tlast",  {63'd0, m_axis.tlast},  {63'd0, m_valid});
            check("tkeep",  {60'd0, m_axis.tkeep},  m_valid ? 64'hF : 64'h0);
            if (m_valid) check("tdata", {32'd0, m_axis.tdata}, {32'd0, m_word});
        end
    end

    // ---------------- stimulus helpers ----------------
    bit rand_ready = 1'b0;

    task automatic tick(input logic b);
        @(negedge clk);
        data_in = b;
        if (rand_ready) m_axis.tready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_byte_msb(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) tick(v[i]);
    endtask

    task automatic send_word_lsb(input logic [31:0] w);
        for (int i = 0; i < DW; i++) tick(w[i]);
    endtask

    task automatic wait_xfer(input int start, input int budget);
        int n = 0;
        while (d_xfers == start && n < budget) begin
            tick(1'b0);
            n++;
        end
        check("xfer_timeout", {63'd0, d_xfers > start}, 64'd1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int start;

        // 1: reset with toggling data
        rst           = 1'b1;
        data_in       = 1'b0;
        m_axis.tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            data_in = ~data_in;
            cmp_en  = 1'b1;
            check("rst_tvalid", {63'd0, m_axis.tvalid}, 64'd0);
            check("rst_tlast",  {63'd0, m_axis.tlast},  64'd0);
            check("rst_tkeep",  {60'd0, m_axis.tkeep},  64'd0);
        end
        check("rst_tdata", {32'd0, m_axis.tdata}, 64'd0);
        @(negedge clk);
        rst     = 1'b0;
        data_in = 1'b0;
        repeat (4) tick(1'b0);

        // 2: basic frame, sink always ready
        start         = d_xfers;
        m_axis.tready = 1'b1;
        send_byte_msb(SFD_V);
        send_word_lsb(32'h7654_3210);
        tick(1'b0);
        check("t2_tvalid_rise", {63'd0, m_axis.tvalid}, 64'd1);
        check("t2_tdata",       {32'd0, m_axis.tdata},  64'h7654_3210);
        check("t2_tkeep",       {60'd0, m_axis.tkeep},  64'hF);
        check("t2_tlast",       {63'd0, m_axis.tlast},  64'd1);
        tick(1'b0);
        check("t2_tvalid_fall", {63'd0, m_axis.tvalid}, 64'd0);
        repeat (10) tick(1'b0);
        check("t2_count",      64'(d_xfers - start), 64'd1);
        check("t2_word",       {32'd0, d_last},      64'h7654_3210);
        check("t2_model_word", {32'd0, m_last},      64'h7654_3210);

        // 3: backpressure, bits during HOLD discarded
        start         = d_xfers;
        m_axis.tready = 1'b0;
        send_byte_msb(SFD_V);
        send_word_lsb(32'hFEDC_BA98);
        for (int i = 0; i < 20; i++) begin
            tick(1'($urandom_range(0, 1)));
            check("t3_hold_valid", {63'd0, m_axis.tvalid}, 64'd1);
            check("t3_hold_data",  {32'd0, m_axis.tdata},  64'hFEDC_BA98);
        end
        check("t3_no_early_xfer", 64'(d_xfers - start), 64'd0);
        m_axis.tready = 1'b1;
        tick(1'b0);
        check("t3_tvalid_fall", {63'd0, m_axis.tvalid}, 64'd0);
        repeat (40) tick(1'b0);
        check("t3_count", 64'(d_xfers - start), 64'd1);
        check("t3_word",  {32'd0, d_last},      64'hFEDC_BA98);

        // 4: noise and partial SFD ahead of the real one
        start = d_xfers;
        send_byte_msb(8'hD4);
        tick(1'b1);
        tick(1'b1);
        send_byte_msb(SFD_V);
        send_word_lsb(32'h7654_3210);
        wait_xfer(start, 10);
        repeat (40) tick(1'b0);
        check("t4_count", 64'(d_xfers - start), 64'd1);
        check("t4_word",  {32'd0, d_last},      64'h7654_3210);

        // 5: delimiter pattern (MSB-first on the wire) embedded in payload
        start = d_xfers;
        send_byte_msb(SFD_V);
        send_word_lsb(32'hAB00_00AB);
        wait_xfer(start, 10);
        repeat (60) tick(1'b0);
        check("t5_count",      64'(d_xfers - start), 64'd1);
        check("t5_word",       {32'd0, d_last},      64'hAB00_00AB);
        check("t5_model_word", {32'd0, m_last},      64'hAB00_00AB);

        // 6: reset in the middle of a capture
        start = d_xfers;
        send_byte_msb(SFD_V);
        for (int i = 0; i < 16; i++) tick(1'($urandom_range(0, 1)));
        rst = 1'b1;
        tick(1'b1);
        rst = 1'b0;
        check("t6_after_rst_tvalid", {63'd0, m_axis.tvalid}, 64'd0);
        repeat (3) tick(1'b0);
        send_byte_msb(SFD_V);
        send_word_lsb(32'hFEDC_BA98);
        wait_xfer(start, 10);
        repeat (40) tick(1'b0);
        check("t6_count", 64'(d_xfers - start), 64'd1);
        check("t6_word",  {32'd0, d_last},      64'hFEDC_BA98);

        // Random phase: noise gaps, random words, random tready
        rand_ready = 1'b1;
        for (int f = 0; f < 60; f++) begin
            int gap = $urandom_range(0, 12);
            for (int g = 0; g < gap; g++) tick(1'($urandom_range(0, 1)));
            send_byte_msb(SFD_V);
            send_word_lsb($urandom);
        end
        rand_ready    = 1'b0;
        m_axis.tready = 1'b1;
        repeat (80) tick(1'b0);
        check("rand_count", 64'(d_xfers), 64'(m_xfers));
        check("rand_last",  {32'd0, d_last}, {32'd0, m_last});

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
